// File: rtl/mem_ram_ctrl_pkg.sv
// Shared constants and types for the RAM port controller.
// State, owner tag and address width live here with the common word constants.
package mem_ram_ctrl_pkg;

    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int unsigned AddrWDefault = 17;
    localparam int unsigned RdLat        = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rtag_t;

endpackage

// File: rtl/mem_ram_rtag.sv
// Read-return pipeline: carries {valid, owner} alongside the RAM latency
// and steers the returning byte into the owning port's read register.
module mem_ram_rtag
    import mem_ram_ctrl_pkg::*;
(
    input  logic       dclk,
    input  logic       rst,
    input  logic       push_i,
    input  owner_e     owner_i,
    input  logic [7:0] ram_din_i,
    output logic [7:0] mem_rdata_o,
    output logic [7:0] if_rdata_o
);

    rtag_t [RdLat-1:0] tag_q;
    rtag_t [RdLat-1:0] tag_d;
    rtag_t             new_tag;
    logic [7:0]        mem_rdata_q;
    logic [7:0]        mem_rdata_d;
    logic [7:0]        if_rdata_q;
    logic [7:0]        if_rdata_d;

    always_comb begin
        new_tag.valid = push_i;
        new_tag.owner = owner_i;
        tag_d         = {tag_q[RdLat-2:0], new_tag};
        mem_rdata_d   = mem_rdata_q;
        if_rdata_d    = if_rdata_q;
        // Oldest tag lines up with the byte the RAM presents now.
        if (tag_q[RdLat-1].valid == Enable) begin
            if (tag_q[RdLat-1].owner == OWN_MEM) begin
                mem_rdata_d = ram_din_i;
            end else begin
                if_rdata_d = ram_din_i;
            end
        end
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            tag_q       <= '0;
            mem_rdata_q <= ZeroWord[7:0];
            if_rdata_q  <= ZeroWord[7:0];
        end else begin
            tag_q       <= tag_d;
            mem_rdata_q <= mem_rdata_d;
            if_rdata_q  <= if_rdata_d;
        end
    end

    assign mem_rdata_o = mem_rdata_q;
    assign if_rdata_o  = if_rdata_q;

endmodule

// File: rtl/mem_ram_ctrl.sv
// Arbitrates the IF and MEM byte ports onto one synchronous RAM.
// Grants are held for a whole burst; reads return through mem_ram_rtag.
module mem_ram_ctrl
    import mem_ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              mem_re_i,
    input  logic [31:0]       mem_raddr_i,
    output logic [7:0]        mem_rdata_o,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_waddr_i,
    input  logic [7:0]        mem_wdata_i,
    input  logic              if_re_i,
    input  logic [31:0]       if_raddr_i,
    output logic [7:0]        if_rdata_o,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] ram_a_q;
    logic [ADDR_W-1:0] ram_a_d;
    logic              ram_wr_q;
    logic              ram_wr_d;
    logic [7:0]        ram_dout_q;
    logic [7:0]        ram_dout_d;
    logic              push;
    owner_e            owner;
    logic              mem_req;
    logic              unused_addr;

    assign mem_req = mem_re_i | mem_we_i;

    assign unused_addr = ^{mem_raddr_i[31:ADDR_W],
                           mem_waddr_i[31:ADDR_W],
                           if_raddr_i[31:ADDR_W]};

    always_comb begin
        state_d    = state_q;
        ram_a_d    = ram_a_q;
        ram_wr_d   = Disable;
        ram_dout_d = ram_dout_q;
        push       = Disable;
        owner      = OWN_MEM;
        unique case (state_q)
            ST_IDLE: begin
                // Write beats read so a protocol-violating we+re pair still stores.
                if (mem_we_i) begin
                    state_d = ST_MEM_WR;
                end else if (mem_re_i) begin
                    state_d = ST_MEM_RD;
                end else if (if_re_i) begin
                    state_d = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                if (if_re_i) begin
                    ram_a_d = if_raddr_i[ADDR_W-1:0];
                    push    = Enable;
                    owner   = OWN_IF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_RD: begin
                if (mem_re_i) begin
                    ram_a_d = mem_raddr_i[ADDR_W-1:0];
                    push    = Enable;
                    owner   = OWN_MEM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (mem_we_i) begin
                    ram_a_d    = mem_waddr_i[ADDR_W-1:0];
                    ram_wr_d   = Enable;
                    ram_dout_d = mem_wdata_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ram_a_q    <= '0;
            ram_wr_q   <= Disable;
            ram_dout_q <= ZeroWord[7:0];
        end else begin
            state_q    <= state_d;
            ram_a_q    <= ram_a_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign if_stall_o = if_re_i &
                        ((state_q != ST_IF_RD) |
                         ((state_q == ST_IDLE) & mem_req));

    assign mem_stall_o = mem_req & (state_q == ST_IF_RD);

    assign ram_a_o    = ram_a_q;
    assign ram_wr_o   = ram_wr_q;
    assign ram_dout_o = ram_dout_q;

    mem_ram_rtag u_rtag (
        .dclk        (dclk),
        .rst         (rst),
        .push_i      (push),
        .owner_i     (owner),
        .ram_din_i   (ram_din_i),
        .mem_rdata_o (mem_rdata_o),
        .if_rdata_o  (if_rdata_o)
    );

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Scoreboard bench for mem_ram_ctrl: stimulus queues expected values,
// a negedge monitor compares them and checks every write strobe.
module tb_mem_ram_ctrl;

    localparam int AW = 17;

    localparam int K_MRD = 0;
    localparam int K_IRD = 1;
    localparam int K_RA  = 2;
    localparam int K_IST = 3;
    localparam int K_MST = 4;
    localparam int K_RWR = 5;
    localparam int K_RDO = 6;

    logic          dclk = 1'b0;
    logic          rst  = 1'b1;
    logic          mem_re;
    logic [31:0]   mem_raddr;
    logic [7:0]    mem_rdata;
    logic          mem_we;
    logic [31:0]   mem_waddr;
    logic [7:0]    mem_wdata;
    logic          if_re;
    logic [31:0]   if_raddr;
    logic [7:0]    if_rdata;
    logic          if_stall;
    logic          mem_stall;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram_mem [0:(1<<AW)-1];

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t expq[$];
    wr_t  wrq[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 dclk = ~dclk;

    mem_ram_ctrl #(.ADDR_W(AW)) dut (
        .dclk        (dclk),
        .rst         (rst),
        .mem_re_i    (mem_re),
        .mem_raddr_i (mem_raddr),
        .mem_rdata_o (mem_rdata),
        .mem_we_i    (mem_we),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata),
        .if_re_i     (if_re),
        .if_raddr_i  (if_raddr),
        .if_rdata_o  (if_rdata),
        .if_stall_o  (if_stall),
        .mem_stall_o (mem_stall),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr),
        .ram_dout_o  (ram_dout),
        .ram_din_i   (ram_din)
    );

    // Synchronous byte RAM; preload on the very first edge.
    always @(posedge dclk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            ram_mem[17'h00100] <= 8'h11;
            ram_mem[17'h00101] <= 8'h22;
            ram_mem[17'h00102] <= 8'h33;
            ram_mem[17'h00103] <= 8'h44;
            ram_mem[17'h00300] <= 8'hA0;
            ram_mem[17'h00301] <= 8'hA1;
            ram_mem[17'h00302] <= 8'hA2;
            ram_mem[17'h1FFFF] <= 8'h5A;
            ram_mem[17'h00000] <= 8'hC3;
        end else if (ram_wr) begin
            ram_mem[ram_a] <= ram_dout;
        end
        ram_din <= ram_mem[ram_a];
    end

    function automatic string kname(input int k);
        case (k)
            K_MRD:   return "mem_rdata";
            K_IRD:   return "if_rdata";
            K_RA:    return "ram_a";
            K_IST:   return "if_stall";
            K_MST:   return "mem_stall";
            K_RWR:   return "ram_wr";
            K_RDO:   return "ram_dout";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_MRD:   return {24'h0, mem_rdata};
            K_IRD:   return {24'h0, if_rdata};
            K_RA:    return {{(32-AW){1'b0}}, ram_a};
            K_IST:   return {31'h0, if_stall};
            K_MST:   return {31'h0, mem_stall};
            K_RWR:   return {31'h0, ram_wr};
            K_RDO:   return {24'h0, ram_dout};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_at(input int kind, input int dly,
                             input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = v;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    always @(negedge dclk) begin
        logic [31:0] act;
        wr_t         w;
        for (int i = expq.size() - 1; i >= 0; i--) begin
            if (expq[i].cyc <= cyc) begin
                n_cmp++;
                act = actual(expq[i].kind);
                if (expq[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: check missed, required %0h",
                             kname(expq[i].kind), expq[i].cyc, expq[i].val);
                end else if (act !== expq[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d: got %0h required %0h",
                             kname(expq[i].kind), cyc, act, expq[i].val);
                end
                expq.delete(i);
            end
        end
        if (ram_wr === 1'b1) begin
            n_cmp++;
            if (wrq.size() == 0) begin
                n_bad++;
                $display("FAIL wr_strobe cyc %0d: got write a=%0h d=%0h required none",
                         cyc, ram_a, ram_dout);
            end else begin
                w = wrq.pop_front();
                if ({{(32-AW){1'b0}}, ram_a} !== w.a || ram_dout !== w.d) begin
                    n_bad++;
                    $display("FAIL wr_strobe cyc %0d: got a=%0h d=%0h required a=%0h d=%0h",
                             cyc, ram_a, ram_dout, w.a, w.d);
                end
            end
        end
    end

    initial begin
        logic [7:0]  rd_bytes [4];
        logic [7:0]  if_bytes [3];
        logic [31:0] word;
        wr_t         w;
        rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        if_bytes = '{8'hA0, 8'hA1, 8'hA2};
        word     = 32'hDEADBEEF;
        mem_re    = 1'b0;
        mem_raddr = 32'h0;
        mem_we    = 1'b0;
        mem_waddr = 32'h0;
        mem_wdata = 8'h0;
        if_re     = 1'b0;
        if_raddr  = 32'h0;

        step();
        expect_at(K_RWR, 0, 32'h0);
        expect_at(K_RA,  0, 32'h0);
        expect_at(K_RDO, 0, 32'h0);
        expect_at(K_MRD, 0, 32'h0);
        expect_at(K_IRD, 0, 32'h0);
        step();
        rst = 1'b0;
        step();

        // MEM and IF request together: MEM wins, IF stalls.
        mem_re    = 1'b1;
        mem_raddr = 32'h100;
        if_re     = 1'b1;
        if_raddr  = 32'h300;
        expect_at(K_IST, 0, 32'h1);
        expect_at(K_MST, 0, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            mem_raddr = 32'h100 + i;
            expect_at(K_IST, 0, 32'h1);
            expect_at(K_MRD, 3, {24'h0, rd_bytes[i]});
            step();
        end
        mem_re = 1'b0;
        expect_at(K_IST, 0, 32'h1);
        step();
        expect_at(K_IST, 0, 32'h1);
        step();

        // IF burst; MEM write arrives mid-burst and must wait.
        for (int i = 0; i < 3; i++) begin
            if_raddr = 32'h300 + i;
            expect_at(K_IST, 0, 32'h0);
            expect_at(K_IRD, 3, {24'h0, if_bytes[i]});
            if (i == 1) begin
                mem_we    = 1'b1;
                mem_waddr = 32'h200;
                mem_wdata = word[7:0];
            end
            if (i >= 1) expect_at(K_MST, 0, 32'h1);
            step();
        end
        if_re = 1'b0;
        expect_at(K_MST, 0, 32'h1);
        expect_at(K_MRD, 2, 32'h44);
        step();
        expect_at(K_MST, 0, 32'h0);
        step();

        for (int i = 0; i < 4; i++) begin
            mem_waddr = 32'h200 + i;
            mem_wdata = word[8*i +: 8];
            w.a = 32'h200 + i;
            w.d = word[8*i +: 8];
            wrq.push_back(w);
            step();
        end
        mem_we = 1'b0;
        step();

        // Read back the stored word.
        expect_at(K_RWR, 0, 32'h0);
        mem_re    = 1'b1;
        mem_raddr = 32'h200;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_raddr = 32'h200 + i;
            expect_at(K_MRD, 3, {24'h0, word[8*i +: 8]});
            step();
        end
        mem_re = 1'b0;
        step();

        // Address wrap at the top of the RAM.
        mem_re    = 1'b1;
        mem_raddr = 32'h0001FFFF;
        step();
        expect_at(K_RA,  1, 32'h1FFFF);
        expect_at(K_MRD, 3, 32'h5A);
        step();
        mem_raddr = 32'h00020000;
        expect_at(K_RA,  1, 32'h0);
        expect_at(K_MRD, 3, 32'hC3);
        step();
        mem_re = 1'b0;
        repeat (4) step();

        // Reset in the middle of a write burst.
        mem_we    = 1'b1;
        mem_waddr = 32'h210;
        mem_wdata = 8'h77;
        step();
        step();
        #3;
        rst    = 1'b1;
        mem_we = 1'b0;
        expect_at(K_RWR, 0, 32'h0);
        expect_at(K_RA,  0, 32'h0);
        expect_at(K_RDO, 0, 32'h0);
        expect_at(K_MRD, 0, 32'h0);
        expect_at(K_IRD, 0, 32'h0);
        step();
        step();
        #2;
        rst = 1'b0;
        step();

        // First grant right after reset release.
        if_re    = 1'b1;
        if_raddr = 32'h300;
        expect_at(K_IST, 0, 32'h1);
        step();
        if_raddr = 32'h301;
        expect_at(K_IST, 0, 32'h0);
        expect_at(K_IRD, 3, 32'hA1);
        expect_at(K_MRD, 3, 32'h0);
        step();
        if_re = 1'b0;
        repeat (6) step();

        foreach (expq[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s cyc %0d: never checked, required %0h",
                     kname(expq[i].kind), expq[i].cyc, expq[i].val);
        end
        foreach (wrq[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_strobe: got no write, required a=%0h d=%0h",
                     wrq[i].a, wrq[i].d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
